mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Sequential arbiter that shares the processor's single 16-bit-address / 32-bit-data memory port between two requesters: instruction fetch and the LDR/STR data path, which is driven by the memory control unit. It grants one requester at a time, registers that requester's address, data and direction, and runs a req/ack handshake with memory. It returns read data or an error with a one-cycle done pulse. A timeout counter bounds every transaction.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 32, memory data width
- TIMEOUT, 255, max cycles waiting for mem_ack; 0 disables the timeout
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2^CNT_W
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held high until f_done
- f_addr  in  ADDR_W  fetch address; fetch is always a read
- f_done  out  1  one-cycle completion pulse to fetch
- f_rdata  out  DATA_W  fetch read data, valid while f_done=1
- f_err  out  1  timeout flag, valid while f_done=1
- d_req  in  1  data request (LDR/STR); held high until d_done
- d_rw  in  1  1=read (LDR), 0=write (STR)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done, d_rdata, d_err  out  1/DATA_W/1  same meaning as the fetch outputs
- mem_req  out  1  transaction active
- mem_rw  out  1  1=read, 0=write
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  memory completion, sampled while mem_req=1
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- grant_data  out  1  1 while the data port owns the bus
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: no transaction.
  - ACCESS: mem_req=1, waiting for mem_ack or timeout.
  - RESP: done pulse to the owning port.
- IDLE with no request: stay in IDLE.
- IDLE with a request, sampled at an edge:
  - Pick the winner.
  - Latch mem_addr, mem_rw and mem_wdata from the winner. Fetch loads mem_rw=1 and mem_wdata=0.
  - Set grant_data.
  - Clear the counter.
  - Go to ACCESS.
- Arbitration:
  - A single requester wins outright.
  - When both request, the port not granted last wins.
  - A last_grant register updates at each grant. It resets to FETCH, so data wins the first tie.
- ACCESS, mem_ack=1: capture mem_rdata (0 for writes), err=0, go to RESP.
- ACCESS, no ack: increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP with err=1 and rdata=0.
- RESP:
  - Assert the owner's done, rdata and err for exactly one cycle. The non-owner's done/err stay 0.
  - Go to IDLE. req sampled at the RESP edge is ignored.
  - The requester drops req (or presents a new request) at that same edge.
- Request inputs are only sampled in IDLE. Changes to addr, wdata or rw during ACCESS have no effect.
- mem_ack while not in ACCESS is ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled externally):
  - state=IDLE.
  - All outputs 0: mem_req, mem_rw, mem_addr, mem_wdata, grant_data, busy, *_done, *_rdata, *_err.
  - last_grant=FETCH, counter=0.
- Reset mid-transaction aborts immediately. No done is issued for the aborted transaction.
- Latency:
  - A request sampled at edge k gives mem_req=1 from edge k.
  - mem_ack sampled at edge k+n gives done=1 during the cycle after edge k+n.
  - mem_req falls at edge k+n.
  - Minimum req-to-done latency is 2 cycles (ack on the first ACCESS cycle).
- Back-to-back: the next grant can be taken at the edge ending RESP+1 (IDLE). Minimum 3 cycles per transaction.
- Timeout: with no ack, err fires TIMEOUT cycles after mem_req rises. mem_req stays high exactly TIMEOUT cycles.
- mem_* outputs are all registered and stable for the whole of ACCESS.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - port ID constants PORT_FETCH=0, PORT_DATA=1
  - RW_READ=1, RW_WRITE=0, matching the memory control unit's read/write encoding
  - default ADDR_W/DATA_W
- Sub-module mem_arb_timer: CNT_W counter with clear/enable inputs and an expired output; TIMEOUT=0 forces expired=0.
- Top: FSM, round-robin tie-break, latches and response registers.

## Test plan
- Reset then f_req=1, f_addr=0x0010, mem_ack after 1 cycle with rdata=0xDEADBEEF -> mem_rw=1, mem_addr=0x0010; f_done one cycle, f_rdata=0xDEADBEEF, f_err=0, d_done=0.
- Store: d_req=1, d_rw=0, d_addr=0x0200, d_wdata=0x12345678, ack after 3 cycles -> mem_rw=0, mem_wdata=0x12345678 for 3 cycles; d_done with d_rdata=0.
- f_req and d_req both high in the same cycle after reset, both held -> data granted first, fetch second, then alternating on each repeated tie.
- TIMEOUT=4, data read with no ack -> mem_req high exactly 4 cycles; d_done=1, d_err=1, d_rdata=0; next request proceeds normally.
- reset_n pulsed low during ACCESS -> all outputs 0 immediately; no done pulse; after release, a tie grants data.
- Change d_addr during ACCESS, plus a stray mem_ack while IDLE -> mem_addr unchanged; no state change or done pulse from the stray ack.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Requester identities, also the encoding of grant_data / last_grant
   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   // Direction encoding shared with the memory control unit
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled.
interface mem_bus_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_done;
   logic [DATA_W-1:0] f_rdata;
   logic              f_err;

   logic              d_req;
   logic              d_rw;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;

   logic              mem_req;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              grant_data;
   logic              busy;

   // Arbiter side
   modport master (
      input  f_req, f_addr, d_req, d_rw, d_addr, d_wdata, mem_ack, mem_rdata,
      output f_done, f_rdata, f_err, d_done, d_rdata, d_err,
             mem_req, mem_rw, mem_addr, mem_wdata, grant_data, busy
   );

   // Requesters and memory side
   modport slave (
      output f_req, f_addr, d_req, d_rw, d_addr, d_wdata, mem_ack, mem_rdata,
      input  f_done, f_rdata, f_err, d_done, d_rdata, d_err,
             mem_req, mem_rw, mem_addr, mem_wdata, grant_data, busy
   );
endinterface

// File: rtl/mem_bus_arbiter_timer.sv
// Transaction timeout counter; TIMEOUT=0 disables expiry.
module mem_arb_timer #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired_c
);
   logic [CNT_W-1:0] r_cnt;

   // Count waiting cycles; cleared when a new transaction is granted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + CNT_W'(1);
   end

   // Expires on the increment that brings the count to TIMEOUT
   assign o_expired_c = (TIMEOUT != 0) && i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / data) arbiter for the single memory port with req/ack
// handshake, round-robin tie-break and per-transaction timeout.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_bus_arbiter_if.master  bus
);
   localparam int unsigned ADDR_W = ADDR_W_DEF;
   localparam int unsigned DATA_W = DATA_W_DEF;

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);
   localparam logic [1:0] S_RESP   = 2'(ST_RESP);

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic              w_grant;
   logic              w_win;
   logic              w_ack_hit;
   logic              w_timeout_hit;
   logic              w_cnt_clr;
   logic              w_cnt_en;
   logic              w_expired_c;

   logic              r_last_grant;
   logic              r_grant_data;
   logic              r_busy;
   logic              r_mem_req;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_f_done;
   logic [DATA_W-1:0] r_f_rdata;
   logic              r_f_err;
   logic              r_d_done;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_d_err;
   logic [DATA_W-1:0] w_resp_data;

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_clr       (w_cnt_clr),
      .i_en        (w_cnt_en),
      .o_expired_c (w_expired_c)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next state, arbitration and transaction-end decode
   always_comb begin
      w_next_state  = r_state;
      w_grant       = 1'b0;
      w_win         = PORT_FETCH;
      w_ack_hit     = 1'b0;
      w_timeout_hit = 1'b0;
      w_cnt_clr     = 1'b0;
      w_cnt_en      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.f_req || bus.d_req) begin
               w_grant      = 1'b1;
               w_cnt_clr    = 1'b1;
               w_next_state = S_ACCESS;
               if (bus.f_req && bus.d_req)
                  w_win = (r_last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
               else
                  w_win = bus.d_req ? PORT_DATA : PORT_FETCH;
            end
         end
         S_ACCESS: begin
            if (bus.mem_ack) begin
               w_ack_hit    = 1'b1;
               w_next_state = S_RESP;
            end else begin
               w_cnt_en = 1'b1;
               if (w_expired_c) begin
                  w_timeout_hit = 1'b1;
                  w_next_state  = S_RESP;
               end
            end
         end
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Write transactions and timeouts return zero data
   assign w_resp_data = (w_ack_hit && (r_mem_rw == RW_READ)) ? bus.mem_rdata : '0;

   // Bus latches at grant and one-cycle response registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= PORT_FETCH;
         r_grant_data <= 1'b0;
         r_busy       <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_rw     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_f_done     <= 1'b0;
         r_f_rdata    <= '0;
         r_f_err      <= 1'b0;
         r_d_done     <= 1'b0;
         r_d_rdata    <= '0;
         r_d_err      <= 1'b0;
      end else begin
         if (w_grant) begin
            r_last_grant <= w_win;
            r_grant_data <= w_win;
            r_busy       <= 1'b1;
            r_mem_req    <= 1'b1;
            r_mem_addr   <= (w_win == PORT_DATA) ? bus.d_addr  : bus.f_addr;
            r_mem_rw     <= (w_win == PORT_DATA) ? bus.d_rw    : RW_READ;
            r_mem_wdata  <= (w_win == PORT_DATA) ? bus.d_wdata : '0;
         end
         if (w_ack_hit || w_timeout_hit) begin
            r_mem_req <= 1'b0;
            if (r_grant_data == PORT_DATA) begin
               r_d_done  <= 1'b1;
               r_d_rdata <= w_resp_data;
               r_d_err   <= w_timeout_hit;
            end else begin
               r_f_done  <= 1'b1;
               r_f_rdata <= w_resp_data;
               r_f_err   <= w_timeout_hit;
            end
         end
         if (r_state == S_RESP) begin
            r_busy       <= 1'b0;
            r_grant_data <= 1'b0;
            r_f_done     <= 1'b0;
            r_f_rdata    <= '0;
            r_f_err      <= 1'b0;
            r_d_done     <= 1'b0;
            r_d_rdata    <= '0;
            r_d_err      <= 1'b0;
         end
      end
   end

   assign bus.mem_req    = r_mem_req;
   assign bus.mem_rw     = r_mem_rw;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.grant_data = r_grant_data;
   assign bus.busy       = r_busy;
   assign bus.f_done     = r_f_done;
   assign bus.f_rdata    = r_f_rdata;
   assign bus.f_err      = r_f_err;
   assign bus.d_done     = r_d_done;
   assign bus.d_rdata    = r_d_rdata;
   assign bus.d_err      = r_d_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=4).
module tb_mem_bus_arbiter;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_fail;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(
      .TIMEOUT (4),
      .CNT_W   (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a stuck run
   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of run, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      reset_n       = 1'b0;
      bus.f_req     = 1'b0;
      bus.f_addr    = '0;
      bus.d_req     = 1'b0;
      bus.d_rw      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;

      // Reset values
      step();
      chk("rst_mem_req",   32'(bus.mem_req),    32'h0);
      chk("rst_mem_rw",    32'(bus.mem_rw),     32'h0);
      chk("rst_mem_addr",  32'(bus.mem_addr),   32'h0);
      chk("rst_mem_wdata", bus.mem_wdata,       32'h0);
      chk("rst_grant",     32'(bus.grant_data), 32'h0);
      chk("rst_busy",      32'(bus.busy),       32'h0);
      chk("rst_f_done",    32'(bus.f_done),     32'h0);
      chk("rst_d_done",    32'(bus.d_done),     32'h0);
      chk("rst_f_rdata",   bus.f_rdata,         32'h0);
      #2 reset_n = 1'b1;

      // Fetch read, ack on first ACCESS cycle
      step();
      bus.f_req  = 1'b1;
      bus.f_addr = 16'h0010;
      step();
      chk("f1_mem_req",   32'(bus.mem_req),    32'h1);
      chk("f1_mem_rw",    32'(bus.mem_rw),     32'h1);
      chk("f1_mem_addr",  32'(bus.mem_addr),   32'h0010);
      chk("f1_mem_wdata", bus.mem_wdata,       32'h0);
      chk("f1_grant",     32'(bus.grant_data), 32'h0);
      chk("f1_busy",      32'(bus.busy),       32'h1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      step();
      chk("f1_done",      32'(bus.f_done),  32'h1);
      chk("f1_rdata",     bus.f_rdata,      32'hDEADBEEF);
      chk("f1_err",       32'(bus.f_err),   32'h0);
      chk("f1_d_done",    32'(bus.d_done),  32'h0);
      chk("f1_req_low",   32'(bus.mem_req), 32'h0);
      bus.mem_ack = 1'b0;
      bus.f_req   = 1'b0;
      step();
      chk("f1_done_off",  32'(bus.f_done),  32'h0);
      chk("f1_idle",      32'(bus.busy),    32'h0);

      // Store, ack after 3 cycles
      bus.d_req   = 1'b1;
      bus.d_rw    = 1'b0;
      bus.d_addr  = 16'h0200;
      bus.d_wdata = 32'h12345678;
      step();
      chk("st_mem_req",   32'(bus.mem_req),    32'h1);
      chk("st_mem_rw",    32'(bus.mem_rw),     32'h0);
      chk("st_mem_addr",  32'(bus.mem_addr),   32'h0200);
      chk("st_mem_wdata", bus.mem_wdata,       32'h12345678);
      chk("st_grant",     32'(bus.grant_data), 32'h1);
      step();
      chk("st_req_c2",    32'(bus.mem_req),    32'h1);
      chk("st_wdata_c2",  bus.mem_wdata,       32'h12345678);
      step();
      chk("st_req_c3",    32'(bus.mem_req),    32'h1);
      chk("st_done_early",32'(bus.d_done),     32'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF0000;
      step();
      chk("st_done",      32'(bus.d_done),  32'h1);
      chk("st_rdata",     bus.d_rdata,      32'h0);
      chk("st_err",       32'(bus.d_err),   32'h0);
      chk("st_f_done",    32'(bus.f_done),  32'h0);
      chk("st_req_low",   32'(bus.mem_req), 32'h0);
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b0;
      step();
      chk("st_done_off",  32'(bus.d_done),  32'h0);

      // Tie after reset: data, fetch, data
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      bus.f_req  = 1'b1;
      bus.f_addr = 16'h0100;
      bus.d_req  = 1'b1;
      bus.d_rw   = 1'b1;
      bus.d_addr = 16'h0300;
      step();
      chk("tie1_grant",   32'(bus.grant_data), 32'h1);
      chk("tie1_addr",    32'(bus.mem_addr),   32'h0300);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hA0A0A0A0;
      step();
      chk("tie1_d_done",  32'(bus.d_done), 32'h1);
      chk("tie1_d_rdata", bus.d_rdata,     32'hA0A0A0A0);
      chk("tie1_f_done",  32'(bus.f_done), 32'h0);
      bus.mem_ack = 1'b0;
      step();
      chk("tie1_idle",    32'(bus.busy),   32'h0);
      step();
      chk("tie2_grant",   32'(bus.grant_data), 32'h0);
      chk("tie2_addr",    32'(bus.mem_addr),   32'h0100);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hB1B1B1B1;
      step();
      chk("tie2_f_done",  32'(bus.f_done), 32'h1);
      chk("tie2_f_rdata", bus.f_rdata,     32'hB1B1B1B1);
      chk("tie2_d_done",  32'(bus.d_done), 32'h0);
      bus.mem_ack = 1'b0;
      step();
      step();
      chk("tie3_grant",   32'(bus.grant_data), 32'h1);
      chk("tie3_addr",    32'(bus.mem_addr),   32'h0300);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hC2C2C2C2;
      step();
      chk("tie3_d_done",  32'(bus.d_done), 32'h1);
      bus.mem_ack = 1'b0;
      bus.f_req   = 1'b0;
      bus.d_req   = 1'b0;
      step();
      chk("tie3_idle",    32'(bus.busy),   32'h0);

      // Timeout on data read: mem_req high exactly 4 cycles
      bus.d_req  = 1'b1;
      bus.d_rw   = 1'b1;
      bus.d_addr = 16'h0400;
      step();
      chk("to_req_c1", 32'(bus.mem_req), 32'h1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("to_req_hold", 32'(bus.mem_req), 32'h1);
         chk("to_no_done",  32'(bus.d_done),  32'h0);
      end
      step();
      chk("to_req_low", 32'(bus.mem_req), 32'h0);
      chk("to_d_done",  32'(bus.d_done),  32'h1);
      chk("to_d_err",   32'(bus.d_err),   32'h1);
      chk("to_d_rdata", bus.d_rdata,      32'h0);
      bus.d_req = 1'b0;
      step();
      chk("to_done_off", 32'(bus.d_done), 32'h0);
      chk("to_err_off",  32'(bus.d_err),  32'h0);
      bus.f_req  = 1'b1;
      bus.f_addr = 16'h0020;
      step();
      chk("to_next_req",  32'(bus.mem_req),  32'h1);
      chk("to_next_addr", 32'(bus.mem_addr), 32'h0020);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h00000055;
      step();
      chk("to_next_done",  32'(bus.f_done), 32'h1);
      chk("to_next_err",   32'(bus.f_err),  32'h0);
      chk("to_next_rdata", bus.f_rdata,     32'h00000055);
      bus.mem_ack = 1'b0;
      bus.f_req   = 1'b0;
      step();

      // Reset during ACCESS
      bus.f_req  = 1'b1;
      bus.f_addr = 16'h0030;
      step();
      chk("ra_mem_req", 32'(bus.mem_req), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("ra_req_off",  32'(bus.mem_req),    32'h0);
      chk("ra_busy_off", 32'(bus.busy),       32'h0);
      chk("ra_addr_off", 32'(bus.mem_addr),   32'h0);
      chk("ra_rw_off",   32'(bus.mem_rw),     32'h0);
      chk("ra_grant_off",32'(bus.grant_data), 32'h0);
      @(posedge clk);
      #3;
      chk("ra_no_done", 32'(bus.f_done), 32'h0);
      bus.d_req  = 1'b1;
      bus.d_rw   = 1'b1;
      bus.d_addr = 16'h0310;
      reset_n    = 1'b1;
      step();
      chk("ra_tie_grant", 32'(bus.grant_data), 32'h1);
      chk("ra_tie_addr",  32'(bus.mem_addr),   32'h0310);
      chk("ra_f_done",    32'(bus.f_done),     32'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h00000066;
      step();
      chk("ra_d_done",  32'(bus.d_done), 32'h1);
      chk("ra_d_rdata", bus.d_rdata,     32'h00000066);
      chk("ra_f_quiet", 32'(bus.f_done), 32'h0);
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b0;
      step();
      step();
      chk("ra_f_grant", 32'(bus.grant_data), 32'h0);
      chk("ra_f_addr",  32'(bus.mem_addr),   32'h0030);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h00000033;
      step();
      chk("ra_f_done2", 32'(bus.f_done), 32'h1);
      bus.mem_ack = 1'b0;
      bus.f_req   = 1'b0;
      step();

      // Input changes during ACCESS, then a stray ack while idle
      bus.d_req   = 1'b1;
      bus.d_rw    = 1'b1;
      bus.d_addr  = 16'h0500;
      bus.d_wdata = 32'h0;
      step();
      chk("chg_addr_c1", 32'(bus.mem_addr), 32'h0500);
      bus.d_addr  = 16'h0666;
      bus.d_rw    = 1'b0;
      bus.d_wdata = 32'h00000099;
      step();
      chk("chg_addr_c2",  32'(bus.mem_addr), 32'h0500);
      chk("chg_rw_c2",    32'(bus.mem_rw),   32'h1);
      chk("chg_wdata_c2", bus.mem_wdata,     32'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h00000077;
      step();
      chk("chg_d_done",  32'(bus.d_done), 32'h1);
      chk("chg_d_rdata", bus.d_rdata,     32'h00000077);
      bus.mem_ack = 1'b0;
      bus.d_req   = 1'b0;
      step();
      chk("chg_idle", 32'(bus.busy), 32'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h00000088;
      step();
      chk("stray_busy",   32'(bus.busy),    32'h0);
      chk("stray_req",    32'(bus.mem_req), 32'h0);
      chk("stray_d_done", 32'(bus.d_done),  32'h0);
      chk("stray_f_done", 32'(bus.f_done),  32'h0);
      step();
      chk("stray_busy2",   32'(bus.busy),   32'h0);
      chk("stray_d_done2", 32'(bus.d_done), 32'h0);
      chk("stray_f_done2", 32'(bus.f_done), 32'h0);
      bus.mem_ack = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
